hssim_frame_ctrl: RTL and testbench
===================================

HSSIM_FRAME_CTRL -- requirements
Module: hssim_frame_ctrl

Interface
REQ-001 SHALL have parameter HIM_LEN, default 16'd520, pixels per row.
REQ-002 SHALL have parameter HIM_ROWS, default 16'd520, rows per frame.
REQ-003 SHALL have parameter HKER_SIZE, default 8'd3, kernel size of the downstream datapath.
REQ-004 SHALL have parameter CLR_CYC, default 8'd4, cycles hclearbuffer_sig is held before streaming.
REQ-005 SHALL have parameter PIPE_LAT, default 8'd12, datapath latency from href_orig to hmu_ref/hsig_ref_sqrd.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-008 SHALL have port start, input, 1, frame request; sampled only in IDLE.
REQ-009 SHALL have port abort, input, 1, cancels the frame from any state.
REQ-010 SHALL have port pix_valid, input, 1, source pixel present.
REQ-011 SHALL have port pix_in, input, 8, source pixel.
REQ-012 SHALL have port pix_ready, output, 1, controller accepts pix_in this cycle.
REQ-013 SHALL have port href_orig, output, 8, registered pixel to the datapath.
REQ-014 SHALL have port hclearbuffer_sig, output, 1, active-high line-buffer clear to the datapath.
REQ-015 SHALL have port col_cnt, output, 16, column of the pixel on href_orig.
REQ-016 SHALL have port row_cnt, output, 16, row of the pixel on href_orig.
REQ-017 SHALL have port res_valid, output, 1, datapath result on this cycle corresponds to a real pixel.
REQ-018 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-019 SHALL have port frame_done, output, 1, one-cycle pulse at frame completion.
REQ-020 SHALL have port underrun_err, output, 1, sticky: a STREAM cycle occurred without pix_valid.

Function
REQ-021 SHALL implement FSM states IDLE, CLEAR, STREAM, FLUSH, DONE.
REQ-022 IDLE->CLEAR on start=1; hclearbuffer_sig=1 for exactly CLR_CYC cycles in CLEAR, then ->STREAM.
REQ-023 In STREAM, pix_ready SHALL be 1 every cycle; an accepted pixel appears on href_orig the next cycle with tag bit 1.
REQ-024 A STREAM cycle with pix_valid=0 SHALL drive href_orig=0 with tag 0, set underrun_err, and advance the counters (no stall; the datapath has no enable).
REQ-025 col_cnt SHALL wrap from HIM_LEN-1 to 0 and increment row_cnt; after column HIM_LEN-1 of row HIM_ROWS-1, ->FLUSH.
REQ-026 In FLUSH, pix_ready=0 and href_orig=0 with tag 0 for PIPE_LAT cycles, then ->DONE.
REQ-027 DONE SHALL last one cycle with frame_done=1, then ->IDLE; counters return to 0.
REQ-028 res_valid SHALL equal the tag bit delayed by exactly PIPE_LAT cycles through a shift register.
REQ-029 abort=1 SHALL take precedence over all transitions: ->IDLE next cycle, tag shift register cleared, frame_done not pulsed, underrun_err kept.
REQ-030 start while busy SHALL be ignored; start and abort together in IDLE SHALL stay in IDLE.
REQ-031 underrun_err SHALL clear only on reset or on IDLE->CLEAR.

Reset
REQ-032 With rst=0 at a clock edge: state IDLE, pix_ready=0, href_orig=0, hclearbuffer_sig=0, col_cnt=0, row_cnt=0, res_valid=0 (shift register cleared), busy=0, frame_done=0, underrun_err=0.
REQ-033 Reset mid-frame SHALL behave identically to power-on reset on the next cycle.

Structure
REQ-034 State encoding and the default values of HIM_LEN/HIM_ROWS/CLR_CYC/PIPE_LAT SHALL live in the shared hssim package.
REQ-035 The PIPE_LAT tag delay SHALL be a single sub-module, hssim_valid_delay (width 1, depth parameter).

Verification (HIM_LEN=8, HIM_ROWS=4, CLR_CYC=4, PIPE_LAT=12)
REQ-036 start pulse, pix_valid=1 continuously -> hclearbuffer_sig high 4 cycles, 32 pixels accepted, first res_valid 12 cycles after first href_orig, 32 res_valid cycles total, frame_done 1 cycle after FLUSH's 12 cycles.
REQ-037 Row wrap: pixel 8 -> col_cnt=0, row_cnt=1 on href_orig.
REQ-038 pix_valid=0 for pixel 5 -> href_orig=0, underrun_err=1 sticky, res_valid low exactly 12 cycles later; frame still completes after 32 STREAM cycles.
REQ-039 abort during pixel 20 -> IDLE next cycle, res_valid stays 0, no frame_done, busy=0.
REQ-040 rst=0 during FLUSH -> all outputs at REQ-032 values next cycle; a new start then produces a full correct frame.
REQ-041 start asserted during STREAM -> no effect on counters or sequencing.

Source files
------------

// File: rtl/hssim_pkg.sv
// Shared definitions for the HSSIM frame controller: state encoding, default
// geometry and timing, and the end-of-frame position test.
package hssim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } hssim_state_e;

    localparam logic [15:0] HSSIM_HIM_LEN   = 16'd520;
    localparam logic [15:0] HSSIM_HIM_ROWS  = 16'd520;
    localparam logic [7:0]  HSSIM_HKER_SIZE = 8'd3;
    localparam logic [7:0]  HSSIM_CLR_CYC   = 8'd4;
    localparam logic [7:0]  HSSIM_PIPE_LAT  = 8'd12;

    // True when (col,row) addresses the final pixel of a frame.
    function automatic logic hssim_is_last(input logic [15:0] col,
                                           input logic [15:0] row,
                                           input logic [15:0] len,
                                           input logic [15:0] rows);
        return (col == (len - 16'd1)) && (row == (rows - 16'd1));
    endfunction

endpackage

// File: rtl/hssim_valid_delay.sv
// Fixed-depth shift register that realigns the pixel tag with the datapath
// output; a clear flushes every stage in one cycle.
module hssim_valid_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    // Shift the tag one stage per cycle; reset or clear empties the pipe.
    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_dout = r_sr[DEPTH-1];

endmodule

// File: rtl/hssim_frame_ctrl.sv
// Frame sequencer for the HSSIM datapath: clears the line buffers, streams one
// frame of pixels without stalling, drains the pipeline and reports completion.
module hssim_frame_ctrl
    import hssim_pkg::*;
#(
    parameter logic [15:0] HIM_LEN   = HSSIM_HIM_LEN,
    parameter logic [15:0] HIM_ROWS  = HSSIM_HIM_ROWS,
    parameter logic [7:0]  HKER_SIZE = HSSIM_HKER_SIZE,
    parameter logic [7:0]  CLR_CYC   = HSSIM_CLR_CYC,
    parameter logic [7:0]  PIPE_LAT  = HSSIM_PIPE_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        pix_valid,
    input  logic [7:0]  pix_in,
    output logic        pix_ready,
    output logic [7:0]  href_orig,
    output logic        hclearbuffer_sig,
    output logic [15:0] col_cnt,
    output logic [15:0] row_cnt,
    output logic        res_valid,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun_err
);

    // The kernel window must fit inside one row of the image.
    if ({8'd0, HKER_SIZE} > HIM_LEN) begin : g_ker_check
        $error("hssim_frame_ctrl: HKER_SIZE exceeds HIM_LEN");
    end

    hssim_state_e r_state;
    logic [7:0]   r_cnt;
    logic [15:0]  r_acol;
    logic [15:0]  r_arow;
    logic         r_pix_ready;
    logic [7:0]   r_href;
    logic         r_tag;
    logic         r_clr;
    logic [15:0]  r_col;
    logic [15:0]  r_row;
    logic         r_busy;
    logic         r_done;
    logic         r_underrun;
    logic         w_res_valid;

    // Frame sequencing FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_acol      <= 16'd0;
            r_arow      <= 16'd0;
            r_pix_ready <= 1'b0;
            r_href      <= 8'd0;
            r_tag       <= 1'b0;
            r_clr       <= 1'b0;
            r_col       <= 16'd0;
            r_row       <= 16'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else if (abort) begin
            // underrun_err deliberately survives an abort
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_acol      <= 16'd0;
            r_arow      <= 16'd0;
            r_pix_ready <= 1'b0;
            r_href      <= 8'd0;
            r_tag       <= 1'b0;
            r_clr       <= 1'b0;
            r_col       <= 16'd0;
            r_row       <= 16'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state    <= ST_CLEAR;
                        r_clr      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_cnt      <= 8'd0;
                        r_underrun <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == (CLR_CYC - 8'd1)) begin
                        r_state     <= ST_STREAM;
                        r_clr       <= 1'b0;
                        r_pix_ready <= 1'b1;
                        r_cnt       <= 8'd0;
                        r_acol      <= 16'd0;
                        r_arow      <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_STREAM: begin
                    // No stall path: a missing pixel becomes a zero bubble.
                    r_href <= pix_valid ? pix_in : 8'd0;
                    r_tag  <= pix_valid;
                    r_col  <= r_acol;
                    r_row  <= r_arow;
                    if (!pix_valid) begin
                        r_underrun <= 1'b1;
                    end else begin
                        r_underrun <= r_underrun;
                    end
                    if (hssim_is_last(r_acol, r_arow, HIM_LEN, HIM_ROWS)) begin
                        r_state     <= ST_FLUSH;
                        r_pix_ready <= 1'b0;
                        r_acol      <= 16'd0;
                        r_arow      <= 16'd0;
                        r_cnt       <= 8'd0;
                    end else if (r_acol == (HIM_LEN - 16'd1)) begin
                        r_acol <= 16'd0;
                        r_arow <= r_arow + 16'd1;
                    end else begin
                        r_acol <= r_acol + 16'd1;
                    end
                end
                ST_FLUSH: begin
                    r_href <= 8'd0;
                    r_tag  <= 1'b0;
                    if (r_cnt == (PIPE_LAT - 8'd1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_col   <= 16'd0;
                        r_row   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= 8'd0;
                    r_pix_ready <= 1'b0;
                    r_href      <= 8'd0;
                    r_tag       <= 1'b0;
                    r_clr       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    hssim_valid_delay #(
        .WIDTH (1),
        .DEPTH (int'(PIPE_LAT))
    ) u_tag_delay (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (abort),
        .i_din  (r_tag),
        .o_dout (w_res_valid)
    );

    assign pix_ready        = r_pix_ready;
    assign href_orig        = r_href;
    assign hclearbuffer_sig = r_clr;
    assign col_cnt          = r_col;
    assign row_cnt          = r_row;
    assign res_valid        = w_res_valid;
    assign busy             = r_busy;
    assign frame_done       = r_done;
    assign underrun_err     = r_underrun;

endmodule

// File: tb/tb_hssim_frame_ctrl.sv
// Directed bench for hssim_frame_ctrl with an 8x4 frame, 4 clear cycles and
// a 12-cycle pipeline: a per-cycle vector table plus whole-frame sequences.
module tb_hssim_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        pix_valid;
    logic [7:0]  pix_in;
    logic        pix_ready;
    logic [7:0]  href_orig;
    logic        hclearbuffer_sig;
    logic [15:0] col_cnt;
    logic [15:0] row_cnt;
    logic        res_valid;
    logic        busy;
    logic        frame_done;
    logic        underrun_err;

    int n_chk  = 0;
    int n_fail = 0;

    hssim_frame_ctrl #(
        .HIM_LEN   (16'd8),
        .HIM_ROWS  (16'd4),
        .HKER_SIZE (8'd3),
        .CLR_CYC   (8'd4),
        .PIPE_LAT  (8'd12)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .pix_valid        (pix_valid),
        .pix_in           (pix_in),
        .pix_ready        (pix_ready),
        .href_orig        (href_orig),
        .hclearbuffer_sig (hclearbuffer_sig),
        .col_cnt          (col_cnt),
        .row_cnt          (row_cnt),
        .res_valid        (res_valid),
        .busy             (busy),
        .frame_done       (frame_done),
        .underrun_err     (underrun_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        start;
        logic        abort;
        logic        pv;
        logic [7:0]  pix;
        logic        e_rdy;
        logic [7:0]  e_href;
        logic        e_clr;
        logic [15:0] e_col;
        logic [15:0] e_row;
        logic        e_busy;
        logic        e_done;
        logic        e_ur;
        logic        e_rv;
    } vec_t;

    vec_t vecs [17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pix_ready"}, {31'd0, pix_ready}, 32'd0);
        chk({tag, ".href"}, {24'd0, href_orig}, 32'd0);
        chk({tag, ".clr"}, {31'd0, hclearbuffer_sig}, 32'd0);
        chk({tag, ".col"}, {16'd0, col_cnt}, 32'd0);
        chk({tag, ".row"}, {16'd0, row_cnt}, 32'd0);
        chk({tag, ".res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".done"}, {31'd0, frame_done}, 32'd0);
        chk({tag, ".underrun"}, {31'd0, underrun_err}, 32'd0);
    endtask

    function automatic logic [7:0] pixval(input int k);
        return 8'((k * 7) + 3);
    endfunction

    // Runs one frame from a start pulse. ur_idx: pixel dropped (-1 none);
    // ab_idx: pixel during which abort is raised (-1 none); rst_fl: reset
    // asserted this many cycles into FLUSH (-1 none).
    task automatic run_frame(input string nm, input int ur_idx, input int ab_idx,
                             input bit mid_start, input int rst_fl);
        int  k = 0;
        int  clr_n = 0;
        int  first_href = -1;
        int  first_rv = -1;
        int  done_cyc = -1;
        int  last_stream = -1;
        int  ab_c = -1;
        int  rv_after_ab = 0;
        int  exp_k = -1;
        bit  exp_tag = 1'b0;
        bit  aborted = 1'b0;
        bit  rv_hist [256];
        int  c;
        for (int i = 0; i < 256; i++) rv_hist[i] = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({nm, ".underrun_cleared"}, {31'd0, underrun_err}, 32'd0);
        for (c = 0; c < 200; c++) begin
            if (hclearbuffer_sig) clr_n++;
            if (res_valid) begin
                rv_hist[c] = 1'b1;
                if (first_rv < 0) first_rv = c;
                if (aborted) rv_after_ab++;
            end
            if (exp_k >= 0) begin
                if (first_href < 0) first_href = c;
                chk($sformatf("%s.href[%0d]", nm, exp_k), {24'd0, href_orig},
                    exp_tag ? {24'd0, pixval(exp_k)} : 32'd0);
                chk($sformatf("%s.col[%0d]", nm, exp_k), {16'd0, col_cnt}, exp_k % 8);
                chk($sformatf("%s.row[%0d]", nm, exp_k), {16'd0, row_cnt}, exp_k / 8);
            end
            if (aborted && c == ab_c + 1) begin
                chk({nm, ".abort_busy"}, {31'd0, busy}, 32'd0);
                chk({nm, ".abort_ready"}, {31'd0, pix_ready}, 32'd0);
                chk({nm, ".abort_href"}, {24'd0, href_orig}, 32'd0);
            end
            if (aborted && frame_done) begin
                chk({nm, ".abort_no_done"}, {31'd0, frame_done}, 32'd0);
            end
            if (frame_done && !aborted) begin
                done_cyc = c;
                chk({nm, ".done_col"}, {16'd0, col_cnt}, 32'd0);
                chk({nm, ".done_row"}, {16'd0, row_cnt}, 32'd0);
                chk({nm, ".done_busy"}, {31'd0, busy}, 32'd1);
                break;
            end
            if (aborted && c >= ab_c + 20) break;
            if (rst_fl >= 0 && last_stream >= 0 && c == last_stream + 1 + rst_fl) begin
                rst = 1'b0;
                step();
                chk_reset_vals({nm, ".rst_flush"});
                rst = 1'b1;
                return;
            end
            exp_k = -1;
            if (pix_ready && !aborted) begin
                start = (mid_start && k == 10) ? 1'b1 : 1'b0;
                if (k == ab_idx) begin
                    abort     = 1'b1;
                    aborted   = 1'b1;
                    ab_c      = c;
                    pix_valid = 1'b1;
                    pix_in    = pixval(k);
                end else begin
                    pix_valid   = (k != ur_idx);
                    pix_in      = (k != ur_idx) ? pixval(k) : 8'hFF;
                    exp_k       = k;
                    exp_tag     = (k != ur_idx);
                    last_stream = c;
                    k++;
                end
            end else begin
                start     = 1'b0;
                abort     = 1'b0;
                pix_valid = 1'b0;
                pix_in    = 8'h00;
            end
            step();
        end
        start     = 1'b0;
        abort     = 1'b0;
        pix_valid = 1'b0;
        if (aborted) begin
            chk({nm, ".abort_rv_after"}, rv_after_ab, 32'd0);
            chk({nm, ".abort_idle_busy"}, {31'd0, busy}, 32'd0);
            chk({nm, ".abort_pixels"}, k, ab_idx);
            return;
        end
        if (done_cyc < 0) begin
            chk({nm, ".timeout_frame_done"}, 32'd0, 32'd1);
            return;
        end
        chk({nm, ".clr_cycles"}, clr_n, 32'd4);
        chk({nm, ".pixels"}, k, 32'd32);
        chk({nm, ".first_href"}, first_href, 32'd5);
        chk({nm, ".first_rv"}, first_rv, 32'd17);
        chk({nm, ".done_cycle"}, done_cyc, last_stream + 13);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s.rv[%0d]", nm, i), {31'd0, rv_hist[first_href + 12 + i]},
                (i == ur_idx) ? 32'd0 : 32'd1);
        end
        chk({nm, ".rv_after_last"}, {31'd0, rv_hist[first_href + 44]}, 32'd0);
        chk({nm, ".underrun"}, {31'd0, underrun_err}, (ur_idx >= 0) ? 32'd1 : 32'd0);
        step();
        chk({nm, ".done_pulse_end"}, {31'd0, frame_done}, 32'd0);
        chk({nm, ".idle_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, ".underrun_sticky"}, {31'd0, underrun_err}, (ur_idx >= 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_in = 8'h00;
        //           rst   st    ab    pv    pix     rdy   href   clr   col     row     busy  done  ur    rv
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,  1'b0, 8'h00, 1'b0, 16'd0,  16'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,  1'b0, 8'h00, 1'b0, 16'd0,  16'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00,  1'b0, 8'h00, 1'b0, 16'd0,  16'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00,  1'b0, 8'h00, 1'b1, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,  1'b0, 8'h00, 1'b1, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,  1'b0, 8'h00, 1'b1, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,  1'b0, 8'h00, 1'b1, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,  1'b1, 8'h00, 1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA0,  1'b1, 8'hA0, 1'b0, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA1,  1'b1, 8'hA1, 1'b0, 16'd1,  16'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA2,  1'b1, 8'hA2, 1'b0, 16'd2,  16'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h55,  1'b1, 8'h00, 1'b0, 16'd3,  16'd0,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hA4,  1'b1, 8'hA4, 1'b0, 16'd4,  16'd0,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA5,  1'b0, 8'h00, 1'b0, 16'd0,  16'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,  1'b0, 8'h00, 1'b0, 16'd0,  16'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00,  1'b0, 8'h00, 1'b1, 16'd0,  16'd0,  1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,  1'b0, 8'h00, 1'b0, 16'd0,  16'd0,  1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            rst       = vecs[i].rst;
            start     = vecs[i].start;
            abort     = vecs[i].abort;
            pix_valid = vecs[i].pv;
            pix_in    = vecs[i].pix;
            step();
            chk($sformatf("vec%0d.pix_ready", i), {31'd0, pix_ready}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("vec%0d.href", i), {24'd0, href_orig}, {24'd0, vecs[i].e_href});
            chk($sformatf("vec%0d.clr", i), {31'd0, hclearbuffer_sig}, {31'd0, vecs[i].e_clr});
            chk($sformatf("vec%0d.col", i), {16'd0, col_cnt}, {16'd0, vecs[i].e_col});
            chk($sformatf("vec%0d.row", i), {16'd0, row_cnt}, {16'd0, vecs[i].e_row});
            chk($sformatf("vec%0d.busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            chk($sformatf("vec%0d.done", i), {31'd0, frame_done}, {31'd0, vecs[i].e_done});
            chk($sformatf("vec%0d.underrun", i), {31'd0, underrun_err}, {31'd0, vecs[i].e_ur});
            chk($sformatf("vec%0d.res_valid", i), {31'd0, res_valid}, {31'd0, vecs[i].e_rv});
        end
        rst = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_in = 8'h00;
        step();

        run_frame("frame_mid_start", -1, -1, 1'b1, -1);
        run_frame("frame_underrun", 5, -1, 1'b0, -1);
        run_frame("frame_abort", -1, 20, 1'b0, -1);
        run_frame("frame_rst_flush", -1, -1, 1'b0, 3);
        step();
        run_frame("frame_after_rst", -1, -1, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
